// File: rtl/tcm_dp_ram.sv
// -----------------------------------------------------------------------------
// tcm_dp_ram - single-clock, dual-port, byte-writable TCM scratchpad.
//
// Port 1 normally serves instruction fetch, port 2 data access (or a core/DMA
// pair in the multi-core build). Both ports are fully pipelined with no
// back-pressure. Every accepted request, read or write, returns one readyN_o
// pulse RD_LATENCY cycles later, with dataN_o valid in that cycle.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   init_busy_o         high while the post-reset zero-clear runs
//   collision_o         1-cycle pulse: both ports wrote overlapping bytes of
//                       the same word in the same cycle (port 1 wins)
//   enN_i, weN_i        request / write enable
//   beN_i               byte enables
//   addrN_i             word address
//   dataN_i / dataN_o   write data / read data (held between ready pulses)
//   readyN_o            completion strobe
// -----------------------------------------------------------------------------

// Per-port return pipeline. Stage 1 is the registered RAM output; stage 2
// (RD_LATENCY = 2) adds an output register. Data registers only load when
// their valid input is set, so the port output holds between pulses.
module tcm_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  acc,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ready_o
);

  logic [RD_LATENCY:1]                 vld_pipe;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc;
      if (acc) dat_pipe[1] <= rdata;
      for (int s = 2; s <= RD_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign ready_o = vld_pipe[RD_LATENCY];
  assign data_o  = dat_pipe[RD_LATENCY];

endmodule

module tcm_dp_ram #(
  parameter int DATA_WIDTH     = 32,
  parameter int N_ENTRIES      = 1024,
  parameter int ADDRW          = $clog2(N_ENTRIES),
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    init_busy_o,
  output logic                    collision_o,
  input  logic                    en1_i,
  input  logic                    we1_i,
  input  logic [DATA_WIDTH/8-1:0] be1_i,
  input  logic [ADDRW-1:0]        addr1_i,
  input  logic [DATA_WIDTH-1:0]   data1_i,
  output logic [DATA_WIDTH-1:0]   data1_o,
  output logic                    ready1_o,
  input  logic                    en2_i,
  input  logic                    we2_i,
  input  logic [DATA_WIDTH/8-1:0] be2_i,
  input  logic [ADDRW-1:0]        addr2_i,
  input  logic [DATA_WIDTH-1:0]   data2_i,
  output logic [DATA_WIDTH-1:0]   data2_o,
  output logic                    ready2_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int NP = 2;  // index 0 = port 1, index 1 = port 2
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(N_ENTRIES - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef struct packed {
    logic             en;
    logic             we;
    logic [NB-1:0]    be;
    logic [ADDRW-1:0] addr;
    word_t            data;
  } req_t;

  typedef struct packed {
    word_t data;
    logic  ready;
  } rsp_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  word_t                  mem [N_ENTRIES];
  state_t                 state;
  logic [ADDRW-1:0]       clr_addr;
  logic                   clr_we;
  logic                   run;
  req_t  [NP-1:0]         req;
  rsp_t  [NP-1:0]         rsp;
  logic  [NP-1:0]         acc;
  logic  [NP-1:0][NB-1:0] wbe;
  word_t [NP-1:0]         rword;

  assign req[0] = '{en: en1_i, we: we1_i, be: be1_i, addr: addr1_i, data: data1_i};
  assign req[1] = '{en: en2_i, we: we2_i, be: be2_i, addr: addr2_i, data: data2_i};

  // ---------------------------------------------------------------------------
  // Clear sequencer: one entry per cycle, N_ENTRIES cycles after reset release.
  // Reset during CLEAR restarts from entry 0 because clr_addr is reset too.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_addr    <= '0;
      init_busy_o <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state       <= ST_RUN;
            init_busy_o <= 1'b0;
          end
        end
        ST_RUN: ;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign run    = (state == ST_RUN);
  assign clr_we = (state == ST_CLEAR) && !rst_i;

  // Requests are dropped outright while clearing; masking the byte enables
  // here keeps every downstream path (write, forward, collision) honest.
  always_comb begin
    acc = '0;
    wbe = '0;
    for (int p = 0; p < NP; p++) begin
      acc[p] = run & req[p].en;
      wbe[p] = (acc[p] & req[p].we) ? req[p].be : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM array (not reset). Port 2 bytes are written first and port 1 bytes
  // last, so on a same-word overlap the later NBA gives port 1 the byte.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int p = NP - 1; p >= 0; p--) begin
        for (int b = 0; b < NB; b++) begin
          if (wbe[p][b]) mem[req[p].addr][8*b +: 8] <= req[p].data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read word feeding stage 1. Read-first returns the stored word; write-first
  // overlays this cycle's writes from both ports in the same priority order as
  // the array update, so the read matches what the array will hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    rword = '0;
    for (int p = 0; p < NP; p++) begin
      rword[p] = mem[req[p].addr];
      if (WRITE_FIRST != 0) begin
        for (int q = NP - 1; q >= 0; q--) begin
          if (req[q].addr == req[p].addr) begin
            for (int b = 0; b < NB; b++) begin
              if (wbe[q][b]) rword[p][8*b +: 8] = req[q].data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Collision timing is fixed at one cycle, independent of RD_LATENCY.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) collision_o <= 1'b0;
    else       collision_o <= (req[0].addr == req[1].addr) && (|(wbe[0] & wbe[1]));
  end

  // ---------------------------------------------------------------------------
  // Per-port return pipelines
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NP; p++) begin : g_port
    tcm_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
    ) u_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .acc     (acc[p]),
      .rdata   (rword[p]),
      .data_o  (rsp[p].data),
      .ready_o (rsp[p].ready)
    );
  end

  assign data1_o  = rsp[0].data;
  assign ready1_o = rsp[0].ready;
  assign data2_o  = rsp[1].data;
  assign ready2_o = rsp[1].ready;

endmodule
